// File: rtl/mem_wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage_if
// Description : Data-memory request/response bus between the MEM stage and
//               the data memory (or cache) port.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_wb_stage_if;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;

  // Pipeline side: issues requests, receives completion and load data
  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload
  );

  // Memory side: receives requests, returns completion and load data
  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload
  );
endinterface
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage
// Description : MEM stage plus MEM/WB register of the 5-stage MIPS pipeline.
//               Issues data-memory accesses, stalls until dhit, holds load
//               data across hazard freezes, resolves branches, registers the
//               writeback result and keeps saturating memory counters.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              memcuDRE,
  input  logic              memcuDWE,
  input  logic              memMemToReg,
  input  logic              memWEN,
  input  logic              memJALflag,
  input  logic [4:0]        memwsel,
  input  logic [31:0]       memOutput_Port,
  input  logic [31:0]       memrdat2,
  input  logic [31:0]       memnpc,
  input  logic              membrnch_eq,
  input  logic              membrnch_ne,
  input  logic              memZero,
  input  logic [31:0]       membrnch_addr,
  input  logic              ext_freeze,
  mem_wb_stage_if.master    dmem,
  output logic              mem_stall,
  output logic              branch_take,
  output logic [31:0]       branch_target,
  output logic              wbWEN,
  output logic [4:0]        wbwsel,
  output logic [31:0]       wbwdat,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  access_cnt,
  output logic              mem_err
);

  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] c_timeout = WCNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HELD = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WCNT_W-1:0]   r_wait_cnt;
  logic [WCNT_W-1:0]   w_wait_nxt;
  logic [31:0]         r_hold_data;
  logic                r_mem_err;
  logic                r_wbWEN;
  logic [4:0]          r_wbwsel;
  logic [31:0]         r_wbwdat;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_access_cnt;

  logic                w_memop;
  logic                w_in_held;
  logic                w_mem_stall;
  logic                w_retire;
  logic [31:0]         w_load_data;
  logic [31:0]         w_wdat;
  logic                w_req_rd;
  logic                w_req_wr;
  logic                w_capture;
  logic                w_err_set;
  logic                w_access;

  assign w_memop     = memcuDRE | memcuDWE;
  assign w_in_held   = (r_state == HELD);
  // Zero-latency on a hit; HELD never stalls because its access is done
  assign w_mem_stall = w_memop & ~dmem.dhit & ~w_in_held;
  assign w_retire    = ~w_mem_stall & ~ext_freeze;
  // Memory may drive new data after the hit, so HELD uses the captured copy
  assign w_load_data = w_in_held ? r_hold_data : dmem.dmemload;
  assign w_wdat      = memJALflag  ? memnpc :
                       memMemToReg ? w_load_data : memOutput_Port;

  assign branch_take   = ((membrnch_eq & memZero) | (membrnch_ne & ~memZero)) & ~ext_freeze;
  assign branch_target = membrnch_addr;

  // Requests are gated by nRST so they drop the instant reset asserts
  assign dmem.dmemREN   = nRST & w_req_rd;
  assign dmem.dmemWEN   = nRST & w_req_wr;
  assign dmem.dmemaddr  = memOutput_Port;
  assign dmem.dmemstore = memrdat2;

  assign mem_stall  = w_mem_stall;
  assign wbWEN      = r_wbWEN;
  assign wbwsel     = r_wbwsel;
  assign wbwdat     = r_wbwdat;
  assign stall_cnt  = r_stall_cnt;
  assign access_cnt = r_access_cnt;
  assign mem_err    = r_mem_err;

  // Next-state, request and bookkeeping decode for the access FSM
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_req_rd    = 1'b0;
    w_req_wr    = 1'b0;
    w_capture   = 1'b0;
    w_err_set   = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      IDLE: begin
        // A load wins if both strobes are (illegally) set
        w_req_rd = memcuDRE;
        w_req_wr = memcuDWE & ~memcuDRE;
        if (w_memop & ~dmem.dhit) begin
          w_state_nxt = WAIT;
          w_wait_nxt  = {{(WCNT_W-1){1'b0}}, 1'b1};
          w_err_set   = (w_wait_nxt == c_timeout);
        end else if (w_memop & dmem.dhit) begin
          w_access = 1'b1;
          if (ext_freeze) begin
            w_state_nxt = HELD;
            w_capture   = 1'b1;
          end
        end
      end
      WAIT: begin
        w_req_rd = memcuDRE;
        w_req_wr = memcuDWE & ~memcuDRE;
        if (dmem.dhit) begin
          w_access    = 1'b1;
          w_wait_nxt  = '0;
          w_capture   = ext_freeze;
          w_state_nxt = ext_freeze ? HELD : IDLE;
        end else if (r_wait_cnt != c_timeout) begin
          w_wait_nxt = r_wait_cnt + 1'b1;
          w_err_set  = (w_wait_nxt == c_timeout);
        end
      end
      HELD: begin
        if (~ext_freeze) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM state, wait timer, held load data and sticky timeout flag
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_wait_cnt  <= '0;
      r_hold_data <= '0;
      r_mem_err   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_capture) begin
        r_hold_data <= dmem.dmemload;
      end
      if (w_err_set) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  // MEM/WB register: bubble when not retiring so a stalled op writes once
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wbWEN  <= 1'b0;
      r_wbwsel <= '0;
      r_wbwdat <= '0;
    end else if (w_retire) begin
      r_wbWEN  <= memWEN;
      r_wbwsel <= memwsel;
      r_wbwdat <= w_wdat;
    end else begin
      r_wbWEN  <= 1'b0;
    end
  end

  // Saturating performance counters
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall_cnt  <= '0;
      r_access_cnt <= '0;
    end else begin
      if (w_mem_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_access && (r_access_cnt != {CNT_W{1'b1}})) begin
        r_access_cnt <= r_access_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory stage plus MEM/WB register of the 5-stage pipelined MIPS core. Sits directly downstream of the EX/MEM register.
- Issues data-memory requests from EX/MEM outputs and waits for dhit. Holds completed load data across pipeline freezes.
- Resolves branches, selects the writeback value, registers it into the WB stage, and keeps memory-stage performance counters.

Parameters:
- TIMEOUT, 256, wait cycles without dhit before the sticky mem_err is set.
- CNT_W, 32, width of the saturating performance counters.

Ports:
- CLK  in  1  clock
- nRST  in  1  async active-low reset
- memcuDRE  in  1  load in MEM
- memcuDWE  in  1  store in MEM
- memMemToReg  in  1  writeback selects load data
- memWEN  in  1  register write enable
- memJALflag  in  1  writeback selects memnpc
- memwsel  in  5  destination register
- memOutput_Port  in  32  ALU result / memory address
- memrdat2  in  32  store data
- memnpc  in  32  PC+4 of MEM instruction
- membrnch_eq  in  1  BEQ in MEM
- membrnch_ne  in  1  BNE in MEM
- memZero  in  1  ALU zero flag
- membrnch_addr  in  32  branch target
- ext_freeze  in  1  hazard unit freeze; MEM instruction must not retire this cycle
- dhit  in  1  data memory done
- dmemload  in  32  load data
- dmemREN  out  1  read request
- dmemWEN  out  1  write request
- dmemaddr  out  32  address, equals memOutput_Port
- dmemstore  out  32  equals memrdat2
- mem_stall  out  1  MEM waiting on memory; upstream holds (exW low)
- branch_take  out  1  branch resolved taken
- branch_target  out  32  equals membrnch_addr
- wbWEN  out  1  registered write enable
- wbwsel  out  5  registered destination
- wbwdat  out  32  registered write data
- stall_cnt  out  CNT_W  cycles with mem_stall high
- access_cnt  out  CNT_W  completed memory accesses
- mem_err  out  1  sticky timeout flag

Behaviour:
- Reset (async, nRST low):
  - State goes to IDLE.
  - wbWEN, wbwsel, wbwdat, hold_data, wait_cnt, stall_cnt, access_cnt and mem_err are all cleared to 0.
  - dmemREN and dmemWEN are forced to 0 while nRST is low.
- memop = memcuDRE | memcuDWE.
- FSM states: IDLE, WAIT, HELD.
- IDLE:
  - Request outputs: dmemREN = memcuDRE and dmemWEN = memcuDWE.
  - memop & ~dhit: go to WAIT; wait_cnt <= 1.
  - memop & dhit & ext_freeze: go to HELD; hold_data <= dmemload.
  - Otherwise stay in IDLE.
- WAIT:
  - Requests stay asserted; wait_cnt increments and saturates at TIMEOUT.
  - On reaching TIMEOUT, set mem_err.
  - dhit & ~ext_freeze: go to IDLE.
  - dhit & ext_freeze: go to HELD and capture hold_data.
- HELD:
  - Requests are 0; the access is never re-issued.
  - ~ext_freeze: go to IDLE.
- mem_stall = memop & ~dhit & (state != HELD). It is combinational, with zero-cycle latency on a hit.
- Load data selection: load_data = hold_data in HELD, else dmemload.
- Writeback value: wdat = memJALflag ? memnpc : (memMemToReg ? load_data : memOutput_Port).
- retire = ~mem_stall & ~ext_freeze.
- WB register, each rising edge:
  - If retire: wbWEN <= memWEN, wbwsel <= memwsel, wbwdat <= wdat.
  - Else: wbWEN <= 0 (bubble); wbwsel and wbwdat hold. This prevents duplicate register writes.
- Branch resolution: branch_take = ((membrnch_eq & memZero) | (membrnch_ne & ~memZero)) & ~ext_freeze. It is combinational.
- Counters (saturating at all-ones; no wrap):
  - stall_cnt increments on every cycle with mem_stall high.
  - access_cnt increments once per access, on the first dhit of that access in IDLE or WAIT. HELD cycles do not increment it.
- Simultaneous memcuDRE and memcuDWE is illegal; dmemREN takes priority and dmemWEN is forced 0.
- Reset mid-WAIT: requests drop immediately, the state returns to IDLE, and no WB write occurs.

Test Plan:
- ALU op, memOutput_Port=0x10, memWEN=1, wsel=3, no memop -> next edge wbWEN=1, wbwsel=3, wbwdat=0x10; mem_stall=0.
- Load, addr 0x40, dhit after 3 cycles, dmemload=0xDEADBEEF -> dmemREN=1 and mem_stall=1 for 3 cycles, wbWEN=0 in those cycles; then wbwdat=0xDEADBEEF; stall_cnt=3, access_cnt=1.
- Load hits with ext_freeze=1 for 2 cycles, dmemload changes to 0 after the hit -> state HELD with dmemREN=0; after release wbwdat equals the captured value; exactly one wbWEN pulse; access_cnt=1.
- BEQ with memZero=1, target 0x100 -> branch_take=1, branch_target=0x100; BNE with memZero=1 -> branch_take=0; JAL, memnpc=0x24 -> wbwdat=0x24, wbwsel=31.
- Store, dhit held low for TIMEOUT cycles -> mem_err=1 and stays 1 after the later dhit; nRST pulse -> mem_err=0, counters=0, dmemWEN=0 immediately.
